instr_fifo: RTL



---
 rtl/vga_pkg.sv | 9 +
 rtl/fifo_mem.sv | 29 ++
 rtl/instr_fifo.sv | 101 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Widths and sizes shared by the instruction path (qspi_controller, buffers, decoder).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int INSTR_W            = 20;
    localparam int FIFO_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/fifo_mem.sv
// Storage array: synchronous write port, combinational read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the caller owns all flow control.
module fifo_mem
    import vga_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array so it can be swapped for a latch bank or SRAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fifo.sv
// Instruction FIFO between QSPI fetch and the decoder: push in, FWFT ready/valid out.
// Latency: 1 cycle write-to-read; no combinational write-to-read bypass.
// Backpressure: almost_full/full advise the pusher; pushes into a full FIFO without a pop are dropped and set sticky overflow.
module instr_fifo
    import vga_pkg::*;
#(
    parameter int DATA_W    = INSTR_W,
    parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int AFULL_LVL = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_nxt;
    logic [DATA_W-1:0] mem_rdata;
    logic              pop;
    logic              push_ok;
    logic              drop;

    assign pop     = rd_valid & rd_ready;
    assign push_ok = wr_en & (~full | pop);
    assign drop    = wr_en & full & ~pop;

    always_comb begin
        level_nxt = level;
        case ({push_ok, pop})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    // Flags are registered from level_nxt so they change on the same edge as level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rd_valid    <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rd_valid    <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level       <= level_nxt;
            rd_valid    <= (level_nxt != '0);
            full        <= (level_nxt == LW'(DEPTH));
            almost_full <= (level_nxt >= LW'(AFULL_LVL));
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok & ~flush),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Gate the head word so rd_data reads zero whenever the FIFO is empty or in reset.
    assign rd_data = rd_valid ? mem_rdata : '0;

endmodule
